// File: rtl/dcache_wb_buffer_if.sv
// Bus bundle between the data cache, the write-back buffer and the memory arbiter.
// slave = the buffer's view; master = the cache/arbiter side that drives it.
interface dcache_wb_buffer_if #(
  parameter int LINE_BITS = 256
);
  logic [31:0]          mem_address;
  logic                 mem_read;
  logic                 mem_write;
  logic [LINE_BITS-1:0] mem_wdata;
  logic [LINE_BITS-1:0] mem_rdata;
  logic                 mem_resp;
  logic [31:0]          pmem_address;
  logic                 pmem_read;
  logic                 pmem_write;
  logic [LINE_BITS-1:0] pmem_wdata;
  logic [LINE_BITS-1:0] pmem_rdata;
  logic                 pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer: absorbs dirty-line evictions, forwards buffered lines, drains FIFO-order.
// Optional macro WBB_READ_PRIORITY_EN: read misses go to memory ahead of pending drains.
module dcache_wb_buffer #(
  parameter int DEPTH     = 4,
  parameter int LINE_BITS = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  dcache_wb_buffer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD_MISS, S_DRAIN, S_RESP} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DEPTH-1:0]     r_valid;
  logic [26:0]          r_tag  [DEPTH];
  logic [LINE_BITS-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [LINE_BITS-1:0] r_mem_rdata;
  logic [31:0]          r_pmem_address;
  logic [LINE_BITS-1:0] r_pmem_wdata;

  logic [DEPTH-1:0]     w_match;
  logic                 w_hit;
  logic [PTR_W-1:0]     w_hit_idx;
  logic                 w_full;
  logic                 w_take_wr;
  logic                 w_fwd;
  logic                 w_push;
  logic                 w_pop;
  logic [PTR_W-1:0]     w_wr_idx;
  logic                 w_load_miss;
  logic                 w_load_drain;

  // Line-address match; at most one entry can hold a given line
  always_comb begin
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (r_tag[i] == bus.mem_address[31:5]);
      w_hit_idx  = w_hit_idx | (w_match[i] ? PTR_W'(i) : '0);
    end
    w_hit = |w_match;
  end

  assign w_full = (r_count == CNT_W'(DEPTH));

  // Next-state decode; requests are only honoured in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_take_wr   = 1'b0;
    w_fwd       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_write && (w_hit || !w_full)) begin
          w_take_wr   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (bus.mem_read && w_hit) begin
          w_fwd       = 1'b1;
          w_state_nxt = S_RESP;
        end else if (bus.mem_read) begin
`ifdef WBB_READ_PRIORITY_EN
          w_state_nxt = S_RD_MISS;
`else
          w_state_nxt = (r_count != '0) ? S_DRAIN : S_RD_MISS;
`endif
        end else if (bus.mem_write) begin
          w_state_nxt = S_DRAIN;
        end else if (r_count != '0) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_MISS: w_state_nxt = bus.pmem_resp ? S_RESP : S_RD_MISS;
      S_DRAIN:   w_state_nxt = bus.pmem_resp ? S_IDLE : S_DRAIN;
      S_RESP:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_push       = w_take_wr && !w_hit;
  assign w_pop        = (r_state == S_DRAIN) && bus.pmem_resp;
  assign w_wr_idx     = w_hit ? w_hit_idx : r_tail;
  assign w_load_miss  = (r_state == S_IDLE) && (w_state_nxt == S_RD_MISS);
  assign w_load_drain = (r_state == S_IDLE) && (w_state_nxt == S_DRAIN);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Entry bookkeeping, read-return data and latched arbiter request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid        <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_mem_rdata    <= '0;
      r_pmem_address <= 32'h0000_0000;
      r_pmem_wdata   <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
        r_count         <= r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
        r_count         <= r_count - CNT_W'(1);
      end
      if (w_fwd) begin
        r_mem_rdata <= r_data[w_hit_idx];
      end else if ((r_state == S_RD_MISS) && bus.pmem_resp) begin
        r_mem_rdata <= bus.pmem_rdata;
      end
      if (w_load_miss) begin
        r_pmem_address <= bus.mem_address;
      end else if (w_load_drain) begin
        r_pmem_address <= {r_tag[r_head], 5'b0_0000};
        r_pmem_wdata   <= r_data[r_head];
      end
    end
  end

  // Line storage; contents are qualified by r_valid so they need no reset
  always_ff @(posedge clk) begin
    if (w_take_wr) begin
      r_tag[w_wr_idx]  <= bus.mem_address[31:5];
      r_data[w_wr_idx] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata    = r_mem_rdata;
  assign bus.mem_resp     = (r_state == S_RESP);
  assign bus.pmem_read    = (r_state == S_RD_MISS);
  assign bus.pmem_write   = (r_state == S_DRAIN);
  assign bus.pmem_address = r_pmem_address;
  assign bus.pmem_wdata   = r_pmem_wdata;
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer with a fixed-latency arbiter responder and transaction log.
module tb_dcache_wb_buffer;
  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           cyc;
  } txn_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   rd_cycles;
  int   wr_cycles;
  int   both_cycles;
  int   resp_cyc;
  int   lat;
  logic pmem_hold;
  txn_t log_q[$];
  txn_t t;

  dcache_wb_buffer_if #(.LINE_BITS(256)) bus ();

  dcache_wb_buffer #(.DEPTH(4), .LINE_BITS(256)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] wline(input logic [31:0] a, input logic [7:0] tg);
    return {8{a ^ {tg, 24'h00_0000}}};
  endfunction

  function automatic logic [255:0] rline(input logic [31:0] a);
    return {8{~a}};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Arbiter model: answers any request on its third sampled cycle and logs it
  initial begin
    int lat_cnt;
    lat_cnt        = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read)  rd_cycles++;
      if (bus.pmem_write) wr_cycles++;
      if (bus.pmem_read && bus.pmem_write) both_cycles++;
      if (!pmem_hold && (bus.pmem_read || bus.pmem_write)) begin
        if (lat_cnt == 2) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = rline(bus.pmem_address);
          log_q.push_back('{bus.pmem_write, bus.pmem_address, bus.pmem_wdata, cyc});
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic issue_write(input logic [31:0] a, input logic [255:0] d);
    bus.mem_address = a;
    bus.mem_wdata   = d;
    bus.mem_write   = 1'b1;
  endtask

  task automatic issue_read(input logic [31:0] a);
    bus.mem_address = a;
    bus.mem_read    = 1'b1;
  endtask

  task automatic wait_resp(input string tag, output int l);
    l = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      l++;
      if (bus.mem_resp) break;
    end
    check(tag, 256'(bus.mem_resp), 256'(1));
    resp_cyc      = cyc;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int q;
    q = 0;
    for (int i = 0; i < 300 && q < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.pmem_read || bus.pmem_write || bus.mem_resp) q = 0;
      else q++;
    end
    check(tag, 256'(q >= 6), 256'(1));
  endtask

  task automatic check_txn(input string tag, input logic wr, input logic [31:0] a,
                           input logic [255:0] d, input logic chk_data);
    if (log_q.size() == 0) begin
      check({tag, "_present"}, 256'(log_q.size()), 256'(1));
    end else begin
      t = log_q.pop_front();
      check({tag, "_kind"}, 256'(t.wr), 256'(wr));
      check({tag, "_addr"}, 256'(t.addr), 256'(a));
      if (chk_data) check({tag, "_data"}, t.data, d);
    end
  endtask

  initial begin
    int rd0;
    int wr0;
    n_cmp = 0; n_bad = 0;
    rd_cycles = 0; wr_cycles = 0; both_cycles = 0;
    pmem_hold       = 1'b0;
    reset_n         = 1'b0;
    bus.mem_address = 32'h0000_0000;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_wdata   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mem_resp",   256'(bus.mem_resp),     256'(0));
    check("rst_pmem_rd_wr", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));
    check("rst_pmem_addr",  256'(bus.pmem_address), 256'(0));
    check("rst_mem_rdata",  bus.mem_rdata,          256'(0));

    // 1: single write acked next cycle, then drained
    issue_write(32'h0000_1000, wline(32'h0000_1000, 8'hD1));
    wait_resp("t1_resp", lat);
    check("t1_lat", 256'(lat), 256'(1));
    wait_quiet("t1_quiet");
    check("t1_nlog", 256'(log_q.size()), 256'(1));
    check_txn("t1_drain", 1'b1, 32'h0000_1000, wline(32'h0000_1000, 8'hD1), 1'b1);
    check("t1_count", 256'(dut.r_count), 256'(0));

    // 2: write then read of the same line is forwarded, no memory read
    rd0 = rd_cycles;
    issue_write(32'h0000_2000, wline(32'h0000_2000, 8'hD2));
    wait_resp("t2_wresp", lat);
    check("t2_wlat", 256'(lat), 256'(1));
    issue_read(32'h0000_2000);
    wait_resp("t2_rresp", lat);
    check("t2_rlat", 256'(lat), 256'(2));
    check("t2_rdata", bus.mem_rdata, wline(32'h0000_2000, 8'hD2));
    wait_quiet("t2_quiet");
    check("t2_no_pmem_read", 256'(rd_cycles - rd0), 256'(0));
    check_txn("t2_drain", 1'b1, 32'h0000_2000, wline(32'h0000_2000, 8'hD2), 1'b1);

    // 3: fill all four entries, fifth write forces the oldest out first
    for (int i = 1; i <= 4; i++) begin
      issue_write(32'(i) << 8, wline(32'(i) << 8, 8'hC0));
      wait_resp("t3_resp", lat);
      check("t3_lat", 256'(lat), (i == 1) ? 256'(1) : 256'(2));
    end
    issue_write(32'h0000_0500, wline(32'h0000_0500, 8'hC0));
    wait_resp("t3_full_resp", lat);
    check("t3_nlog_at_ack", 256'(log_q.size()), 256'(1));
    check_txn("t3_evict", 1'b1, 32'h0000_0100, wline(32'h0000_0100, 8'hC0), 1'b1);
    wait_quiet("t3_quiet");
    check("t3_nlog", 256'(log_q.size()), 256'(4));
    for (int i = 2; i <= 5; i++) begin
      check_txn("t3_order", 1'b1, 32'(i) << 8, wline(32'(i) << 8, 8'hC0), 1'b1);
    end

    // 4: back-to-back writes to one line merge into a single writeback
    issue_write(32'h0000_3000, wline(32'h0000_3000, 8'hD3));
    wait_resp("t4_resp1", lat);
    issue_write(32'h0000_3000, wline(32'h0000_3000, 8'hD4));
    wait_resp("t4_resp2", lat);
    check("t4_lat2", 256'(lat), 256'(2));
    wait_quiet("t4_quiet");
    check("t4_nlog", 256'(log_q.size()), 256'(1));
    check_txn("t4_merge", 1'b1, 32'h0000_3000, wline(32'h0000_3000, 8'hD4), 1'b1);

    // 5: read miss with one line pending; ordering depends on the priority option
    issue_write(32'h0000_4000, wline(32'h0000_4000, 8'hD5));
    wait_resp("t5_wresp", lat);
    issue_read(32'h0000_8000);
    wait_resp("t5_rresp", lat);
    check("t5_rdata", bus.mem_rdata, rline(32'h0000_8000));
    if (log_q.size() == 0) begin
      check("t5_rlog", 256'(log_q.size()), 256'(1));
    end else begin
      check("t5_rlat_kind", 256'(log_q[$].wr), 256'(0));
      check("t5_rlat", 256'(resp_cyc), 256'(log_q[$].cyc + 1));
    end
    wait_quiet("t5_quiet");
    check("t5_nlog", 256'(log_q.size()), 256'(2));
`ifdef WBB_READ_PRIORITY_EN
    check_txn("t5_first",  1'b0, 32'h0000_8000, 256'(0), 1'b0);
    check_txn("t5_second", 1'b1, 32'h0000_4000, wline(32'h0000_4000, 8'hD5), 1'b1);
`else
    check_txn("t5_first",  1'b1, 32'h0000_4000, wline(32'h0000_4000, 8'hD5), 1'b1);
    check_txn("t5_second", 1'b0, 32'h0000_8000, 256'(0), 1'b0);
`endif

    // 6: reset in the middle of a drain drops the request immediately
    pmem_hold = 1'b1;
    issue_write(32'h0000_6000, wline(32'h0000_6000, 8'hD6));
    wait_resp("t6_wresp", lat);
    for (int i = 0; i < 20; i++) begin
      if (bus.pmem_write) break;
      @(posedge clk);
      #1;
    end
    check("t6_draining", 256'(bus.pmem_write), 256'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_pmem_write", 256'(bus.pmem_write),   256'(0));
    check("t6_rst_pmem_addr",  256'(bus.pmem_address), 256'(0));
    check("t6_rst_pmem_wdata", bus.pmem_wdata,         256'(0));
    @(negedge clk);
    pmem_hold = 1'b0;
    reset_n   = 1'b1;
    rd0 = rd_cycles;
    wr0 = wr_cycles;
    repeat (12) @(posedge clk);
    #1;
    check("t6_no_traffic", 256'((rd_cycles - rd0) + (wr_cycles - wr0)), 256'(0));
    check("t6_count", 256'(dut.r_count), 256'(0));
    check("t6_nlog", 256'(log_q.size()), 256'(0));
    check("rd_wr_exclusive", 256'(both_cycles), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
